// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan controller.
// Blank/dash glyph codes, scan state enum, small elaboration helper.
package seg7_pkg;

  localparam logic [3:0] DIG_BLANK = 4'd15;
  localparam logic [3:0] DIG_DASH  = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } scan_state_t;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Phase counter for the scan controller: counts up from 0, clears on iCLR.
// Ports: iCLK, iRST (sync, high), iCLR, iTC (terminal count), oCNT, oDONE.
module seg7_scan_timer #(
  parameter int W = 4
) (
  input  logic         iCLK,
  input  logic         iRST,
  input  logic         iCLR,
  input  logic [W-1:0] iTC,
  output logic [W-1:0] oCNT,
  output logic         oDONE
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      cnt_q <= '0;
    end else if (iCLR) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  // done is high during the last cycle of a phase of iTC cycles
  assign oDONE = (cnt_q == iTC - W'(1));
  assign oCNT  = cnt_q;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexes one SEG7 decoder over NUM_DIGITS common-anode digits with a
// double-buffered digit snapshot and a blank gap before each digit.
// Ports: iCLK, iRST (sync, high), iEN, iLOAD, iDATA -> oDIG, oAN (low), oFRAME.
// Build option SEG7_LEADING_ZERO_BLANK_EN: suppress leading zero digits.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic                    iEN,
  input  logic                    iLOAD,
  input  logic [4*NUM_DIGITS-1:0] iDATA,
  output logic [3:0]              oDIG,
  output logic [NUM_DIGITS-1:0]   oAN,
  output logic                    oFRAME
);

  localparam int CW = $clog2(imax(SCAN_DIV, BLANK_CYCLES) + 1);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [IW-1:0] LAST     = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] TC_SHOW  = CW'(SCAN_DIV);
  localparam logic [CW-1:0] TC_BLANK = CW'(BLANK_CYCLES);
  localparam logic [CW-1:0] SHOW_END = CW'(SCAN_DIV - 1);

  scan_state_t state_q, state_d;

  logic [IW-1:0] idx_q, idx_d;

  logic [NUM_DIGITS-1:0][3:0] act_q;
  logic [NUM_DIGITS-1:0][3:0] pend_q;
  logic [NUM_DIGITS-1:0][3:0] shown;
  logic                       pvld_q;

  logic [CW-1:0] cnt, cnt_nxt, tc;
  logic          done, clr, swap;

  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0]            dig_q, dig_d;
  logic                  frame_q, frame_d;

  assign tc = (state_q == SHOW) ? TC_SHOW : TC_BLANK;

  seg7_scan_timer #(
    .W(CW)
  ) u_timer (
    .iCLK (iCLK),
    .iRST (iRST),
    .iCLR (clr),
    .iTC  (tc),
    .oCNT (cnt),
    .oDONE(done)
  );

  assign cnt_nxt = clr ? '0 : cnt + CW'(1);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic zabove;
`endif

  always_comb begin
    shown = act_q;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    zabove = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zabove = zabove & (act_q[k] == 4'd0);
      if (zabove) shown[k] = DIG_BLANK;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clr     = 1'b0;
    swap    = 1'b0;
    an_d    = '1;
    dig_d   = DIG_BLANK;
    frame_d = 1'b0;
    if (!iEN) begin
      state_d = IDLE;
      idx_d   = '0;
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = BLANK;
          idx_d   = '0;
          clr     = 1'b1;
          swap    = 1'b1;
        end
        BLANK: begin
          if (done) begin
            state_d = SHOW;
            clr     = 1'b1;
          end
        end
        SHOW: begin
          if (done) begin
            state_d = BLANK;
            clr     = 1'b1;
            if (idx_q == LAST) begin
              idx_d = '0;
              swap  = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          clr     = 1'b1;
        end
      endcase
    end
    if (state_d == SHOW) begin
      an_d[idx_d] = 1'b0;
      dig_d       = shown[idx_d];
      // flag the final lit cycle of the last digit: the frame ends
      // and the buffer swap happens on the edge closing this cycle
      frame_d = (idx_d == LAST) && (cnt_nxt == SHOW_END);
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      an_q    <= '1;
      dig_q   <= DIG_BLANK;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      dig_q   <= dig_d;
      frame_q <= frame_d;
    end
  end

  // a load coinciding with a swap bypasses pending and lands in active
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      act_q  <= '0;
      pend_q <= '0;
      pvld_q <= 1'b0;
    end else if (swap) begin
      if (iLOAD) begin
        act_q <= iDATA;
      end else if (pvld_q) begin
        act_q <= pend_q;
      end
      pvld_q <= 1'b0;
    end else if (iLOAD) begin
      pend_q <= iDATA;
      pvld_q <= 1'b1;
    end
  end

  assign oAN    = an_q;
  assign oDIG   = dig_q;
  assign oFRAME = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed scoreboard bench for seg7_scan_ctrl (4 digits, SHOW=4, BLANK=1).
// Honours SEG7_LEADING_ZERO_BLANK_EN in its expected-value model.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dig;
  logic [3:0]  an;
  logic        frame;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] dig;
    logic       fr;
  } exp_t;

  exp_t q[$];

  seg7_scan_ctrl #(
    .NUM_DIGITS  (4),
    .SCAN_DIV    (4),
    .BLANK_CYCLES(1)
  ) dut (
    .iCLK  (clk),
    .iRST  (rst),
    .iEN   (en),
    .iLOAD (load),
    .iDATA (data),
    .oDIG  (dig),
    .oAN   (an),
    .oFRAME(frame)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push1(input logic [3:0] a, input logic [3:0] d,
                       input logic f);
    exp_t e;
    e.an  = a;
    e.dig = d;
    e.fr  = f;
    q.push_back(e);
  endtask

  // expected frame starting at its first blank cycle; first n cycles only
  task automatic push_frame(input logic [15:0] d, input int n);
    logic [3:0] sh [4];
    logic       z;
    int         off;
    for (int k = 0; k < 4; k++) sh[k] = d[4*k +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    z = 1'b1;
    for (int k = 3; k > 0; k--) begin
      z = z & (d[4*k +: 4] == 4'd0);
      if (z) sh[k] = 4'd15;
    end
`else
    z = 1'b0;
`endif
    off = 0;
    for (int k = 0; k < 4; k++) begin
      if (off < n) push1(4'hF, 4'd15, 1'b0);
      off++;
      for (int c = 0; c < 4; c++) begin
        if (off < n) push1(~(4'b0001 << k), sh[k], (k == 3) && (c == 3));
        off++;
      end
    end
  endtask

  task automatic run(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL sb_underflow cyc=%0d observed=0 expected=1", cyc);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("an", {4'h0, an}, {4'h0, e.an});
        chk("dig", {4'h0, dig}, {4'h0, e.dig});
        chk("frame", {7'h0, frame}, {7'h0, e.fr});
      end
    end
  endtask

  initial begin
    tick();
    tick();
    chk("rst_an", {4'h0, an}, 8'h0F);
    chk("rst_dig", {4'h0, dig}, 8'h0F);
    chk("rst_frame", {7'h0, frame}, 8'h00);
    rst = 1'b0;
    push1(4'hF, 4'd15, 1'b0);
    run(1);

    // 1: first frame shows zeros, load lands at the frame boundary
    push_frame(16'h0000, 20);
    en = 1'b1;
    run(1);
    load = 1'b1;
    data = 16'h4321;
    run(1);
    load = 1'b0;
    run(18);
    push_frame(16'h4321, 20);
    run(20);

    // 2: load at digit 2 must not tear the current frame
    push_frame(16'h4321, 20);
    run(12);
    load = 1'b1;
    data = 16'h9999;
    run(1);
    load = 1'b0;
    run(7);

    // 3: pending load, then a load coincident with the swap wins
    push_frame(16'h9999, 20);
    run(10);
    load = 1'b1;
    data = 16'h1111;
    run(1);
    load = 1'b0;
    run(9);
    load = 1'b1;
    data = 16'h0A05;
    push_frame(16'h0A05, 20);
    run(1);
    load = 1'b0;
    checks++;
    assert (dut.pvld_q === 1'b0) else begin
      errors++;
      $error("FAIL pend_valid observed=%b expected=0", dut.pvld_q);
    end
    run(19);
    push_frame(16'h0A05, 20);
    run(20);

    // 4: drop enable in digit 1, load while idle, re-enable
    push_frame(16'h0A05, 7);
    run(7);
    en = 1'b0;
    push1(4'hF, 4'd15, 1'b0);
    run(1);
    load = 1'b1;
    data = 16'h0123;
    push1(4'hF, 4'd15, 1'b0);
    run(1);
    load = 1'b0;
    push1(4'hF, 4'd15, 1'b0);
    run(1);
    en = 1'b1;
    push_frame(16'h0123, 20);
    run(20);

    // 5: reset mid-SHOW with a coincident load
    push_frame(16'h0123, 3);
    run(3);
    rst = 1'b1;
    load = 1'b1;
    data = 16'hFFFF;
    push1(4'hF, 4'd15, 1'b0);
    run(1);
    rst = 1'b0;
    load = 1'b0;

    // 6: zero-heavy patterns
    push_frame(16'h0000, 20);
    run(2);
    load = 1'b1;
    data = 16'h0070;
    run(1);
    load = 1'b0;
    run(17);
    push_frame(16'h0070, 20);
    run(2);
    load = 1'b1;
    data = 16'h0000;
    run(1);
    load = 1'b0;
    run(17);
    push_frame(16'h0000, 20);
    run(20);

    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL sb_left observed=%0d expected=0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
